// File: rtl/mem_wait_ram.sv
// Word-addressed data RAM with programmable wait states and an MFC handshake.
// Single port; the array is touched only on the completion edge of a request.
module mem_wait_ram #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 6,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_en,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              mfc,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, state_d;
    logic [3:0]        cnt, cnt_d;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              accept;
    logic              commit;
    logic              in_range;

    logic [DATA_W-1:0] mem [DEPTH];

    assign in_range = 32'(addr_q) < DEPTH;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_en) begin
                    accept  = 1'b1;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!mem_en) begin
                    state_d = IDLE;
                end else if (cnt != 4'd0) begin
                    cnt_d = cnt - 4'd1;
                end else begin
                    commit  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!mem_en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata   <= '0;
            mfc     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            mfc   <= (state_d == DONE);
            busy  <= (state_d != IDLE);
            if (accept) begin
                rw_q    <= rw;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            // Out-of-range reads complete normally but return zero
            if (commit && rw_q) begin
                rdata <= in_range ? mem[addr_q] : '0;
            end
        end
    end

    // Array has no reset; reset forces IDLE so commit cannot fire
    always_ff @(posedge clk) begin
        if (commit && !rw_q && in_range) begin
            mem[addr_q] <= wdata_q;
        end
    end

endmodule

// File: doc/mem_wait_ram.md
Name: mem_wait_ram

Overview:
- Word-addressed data memory for the microcontroller datapath, sitting directly downstream of the load/store control FSM.
- Receives the memory enable, read/write select, address (from MAR) and write data (from MDR).
- Performs the access after a programmable number of wait states, then raises MFC (memory function complete) and holds it until the controller releases the enable.
- Read data is presented on a registered output for MDR capture.

Parameters:
DATA_W, 16, data word width (matches instruction/register width)
ADDR_W, 6, address width
DEPTH, 64, implemented words; must be <= 2**ADDR_W
WAIT_CYCLES, 2, wait states between request acceptance and MFC; legal range 0..15

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
mem_en  input  1  access request; held high by controller until MFC seen
rw  input  1  1 = read, 0 = write
addr  input  ADDR_W  word address (MAR contents)
wdata  input  DATA_W  write data (MDR contents)
rdata  output  DATA_W  registered read data; valid while mfc high after a read
mfc  output  1  memory function complete
busy  output  1  high in BUSY and DONE states

Behaviour:
- Reset (async, rst high):
  - state=IDLE; mfc=0; busy=0; rdata=0; wait counter=0; latched rw/addr/wdata=0.
  - Array contents are not reset; they are retained across rst.
- States: IDLE, BUSY, DONE. State register, counter and outputs are all registered. No combinational path from inputs to outputs.
- IDLE:
  - mem_en sampled high at edge k -> latch rw, addr and wdata; load counter with WAIT_CYCLES; go to BUSY; busy=1.
  - mem_en low -> stay in IDLE.
- BUSY:
  - mem_en sampled low -> abort: go to IDLE, busy=0. The write is NOT committed and rdata is unchanged.
  - Else if counter != 0 -> decrement and stay in BUSY.
  - Else (counter == 0) -> go to DONE and set mfc=1.
    - Read: rdata <= mem[latched addr].
    - Write: mem[latched addr] <= latched wdata; rdata unchanged.
- Latency: mfc rises at edge k+WAIT_CYCLES+1, where k is the accept edge. With WAIT_CYCLES=0, mfc is high one edge after accept.
- DONE:
  - mfc and busy stay high while mem_en stays high; rdata is held stable.
  - mem_en sampled low -> go to IDLE; mfc=0, busy=0. rdata keeps its last value.
- Back-to-back accesses: each new request requires mem_en low for at least one sampled edge, which returns the block to IDLE. A request can be accepted on the edge after returning to IDLE.
- Request fields (rw, addr, wdata) are sampled only at acceptance. Changes during BUSY or DONE are ignored.
- Out of range (latched addr >= DEPTH):
  - Read returns 0.
  - Write is dropped.
  - MFC timing is unchanged, so the controller never hangs.
- Single port: exactly one array access per request, performed on the completion edge only.
- Reset during BUSY or DONE: immediate return to IDLE with mfc=0, and no array write occurs.

Test Plan:
- Reset: assert rst mid-BUSY of a write (addr 5, data 16'h1234) -> mfc=0, busy=0 immediately. A following read of addr 5 returns the prior contents, not 16'h1234.
- Write then read, WAIT_CYCLES=2: write 16'hBEEF to addr 3, accept at edge k -> mfc high at k+3. Drop mem_en -> mfc low next edge. Read addr 3 -> rdata=16'hBEEF when mfc rises at k'+3.
- MFC hold: keep mem_en high 5 cycles after mfc during a read of addr 3 -> mfc and rdata=16'hBEEF stable throughout. Change addr to 4 mid-hold -> rdata unchanged.
- Abort: write 16'h5555 to addr 7 and drop mem_en after 1 BUSY cycle -> mfc never rises. A read of addr 7 returns the old value.
- Boundary: DEPTH=48; write 16'hAAAA to addr 50 then read addr 50 -> mfc asserted with normal latency each time, rdata=0. A read of addr 47 (last word) succeeds with its written data.
- Zero wait: WAIT_CYCLES=0, read addr 0 -> mfc high at accept+1. Back-to-back reads with one idle cycle between -> second accepted correctly.
